// File: rtl/misc_xfr_deframer.sv
// misc_xfr_deframer
// Receive-side deframer for the misc aggregated-transfer stream. A block is
// 128 beats of 256 bits: link data beats, then an optional interval-stat beat,
// then zero-fill up to beat 127. The block restores big-endian byte order,
// forwards data, drops fill, extracts interval timestamps, flags protocol
// errors and keeps saturating statistics.
//
// Ports
//   iCLK, iRST_N    clock, synchronous active-low reset
//   iXFR_DATA       incoming beat (DATA_WIDTH)
//   iXFR_DATA_V     beat valid, no backpressure
//   iXFR_SOB        start of block, qualified by iXFR_DATA_V
//   iCNT_CLR        clear all statistics counters
//   oDATA/oDATA_V   forwarded big-endian data beat
//   oINTV_TS/oINTV_V  last interval timestamp and its update pulse
//   oBLK_DONE       pulse when beat 127 of a block is consumed
//   oERR_SHORT      SOB arrived mid-block (previous block truncated)
//   oERR_ORPHAN     valid beat without SOB while idle
//   oERR_ZFILL      non-zero beat inside zero-fill
//   oDATA_CNT/oINTV_CNT/oZERO_CNT  saturating beat counters
module misc_xfr_deframer #(
  parameter int DATA_WIDTH = 256,
  parameter bit BIG_ENDIAN = 1'b0,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic [DATA_WIDTH-1:0] iXFR_DATA,
  input  logic                  iXFR_DATA_V,
  input  logic                  iXFR_SOB,
  input  logic                  iCNT_CLR,
  output logic [DATA_WIDTH-1:0] oDATA,
  output logic                  oDATA_V,
  output logic [55:0]           oINTV_TS,
  output logic                  oINTV_V,
  output logic                  oBLK_DONE,
  output logic                  oERR_SHORT,
  output logic                  oERR_ORPHAN,
  output logic                  oERR_ZFILL,
  output logic [CNT_WIDTH-1:0]  oDATA_CNT,
  output logic [CNT_WIDTH-1:0]  oINTV_CNT,
  output logic [CNT_WIDTH-1:0]  oZERO_CNT
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, BLK, ZFILL} state_t;

  state_t                  state, stateNxt;
  logic [6:0]              beatCnt, beatCntNxt, pos;
  logic [DATA_WIDTH-1:0]   swapped, be;
  logic                    isZero, isIntv;
  logic                    fwd, intvHit, zeroHit;
  logic                    errShort, errOrphan, errZfill, blkDone;
  logic                    fillMode;

  // Byte k <-> byte NUM_BYTES-1-k.
  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_swap
    assign swapped[8*k +: 8] = iXFR_DATA[8*(NUM_BYTES-1-k) +: 8];
  end

  assign be     = BIG_ENDIAN ? iXFR_DATA : swapped;
  assign isZero = (be == '0);
  assign isIntv = (be[7:0] == 8'h07) && (be[DATA_WIDTH-1:64] == '0);

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state   <= IDLE;
      beatCnt <= '0;
    end else begin
      state   <= stateNxt;
      beatCnt <= beatCntNxt;
    end
  end

  always_comb begin
    stateNxt   = state;
    beatCntNxt = beatCnt;
    pos        = beatCnt;
    fillMode   = 1'b0;
    fwd        = 1'b0;
    intvHit    = 1'b0;
    zeroHit    = 1'b0;
    errShort   = 1'b0;
    errOrphan  = 1'b0;
    errZfill   = 1'b0;
    blkDone    = 1'b0;
    if (iXFR_DATA_V) begin
      if (state == IDLE && !iXFR_SOB) begin
        errOrphan = 1'b1;
      end else begin
        // Any SOB restarts the block at beat 0; mid-block it also truncates
        // the previous block.
        errShort = iXFR_SOB && (state != IDLE) && (beatCnt != '0);
        pos      = iXFR_SOB ? 7'd0 : beatCnt;
        fillMode = !iXFR_SOB && (state == ZFILL);
        if (fillMode) begin
          if (isZero) zeroHit  = 1'b1;
          else        errZfill = 1'b1;
          stateNxt = ZFILL;
        end else if (isZero) begin
          zeroHit  = 1'b1;
          stateNxt = ZFILL;
        end else if (isIntv) begin
          intvHit  = 1'b1;
          stateNxt = ZFILL;
        end else begin
          fwd      = 1'b1;
          stateNxt = BLK;
        end
        // 7-bit counter wraps 127 -> 0 on its own.
        beatCntNxt = pos + 7'd1;
        if (pos == 7'd127) begin
          blkDone  = 1'b1;
          stateNxt = IDLE;
        end
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      oDATA       <= '0;
      oDATA_V     <= 1'b0;
      oINTV_TS    <= '0;
      oINTV_V     <= 1'b0;
      oBLK_DONE   <= 1'b0;
      oERR_SHORT  <= 1'b0;
      oERR_ORPHAN <= 1'b0;
      oERR_ZFILL  <= 1'b0;
    end else begin
      oDATA_V     <= fwd;
      oINTV_V     <= intvHit;
      oBLK_DONE   <= blkDone;
      oERR_SHORT  <= errShort;
      oERR_ORPHAN <= errOrphan;
      oERR_ZFILL  <= errZfill;
      if (fwd)     oDATA    <= be;
      if (intvHit) oINTV_TS <= be[63:8];
    end
  end

  // Saturating counters; clear wins over a same-cycle increment.
  always_ff @(posedge iCLK) begin
    if (!iRST_N || iCNT_CLR) begin
      oDATA_CNT <= '0;
      oINTV_CNT <= '0;
      oZERO_CNT <= '0;
    end else begin
      if (fwd && oDATA_CNT != '1)     oDATA_CNT <= oDATA_CNT + 1'b1;
      if (intvHit && oINTV_CNT != '1) oINTV_CNT <= oINTV_CNT + 1'b1;
      if (zeroHit && oZERO_CNT != '1) oZERO_CNT <= oZERO_CNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_misc_xfr_deframer.sv
module tb_misc_xfr_deframer;

  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic           iCLK = 1'b0;
  logic           iRST_N = 1'b0;
  logic [255:0]   iXFR_DATA = '0;
  logic           iXFR_DATA_V = 1'b0;
  logic           iXFR_SOB = 1'b0;
  logic           iCNT_CLR = 1'b0;
  logic [255:0]   oDATA;
  logic           oDATA_V;
  logic [55:0]    oINTV_TS;
  logic           oINTV_V, oBLK_DONE, oERR_SHORT, oERR_ORPHAN, oERR_ZFILL;
  logic [CW-1:0]  oDATA_CNT, oINTV_CNT, oZERO_CNT;

  misc_xfr_deframer #(.DATA_WIDTH(256), .BIG_ENDIAN(1'b0), .CNT_WIDTH(CW)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iXFR_DATA(iXFR_DATA), .iXFR_DATA_V(iXFR_DATA_V),
    .iXFR_SOB(iXFR_SOB), .iCNT_CLR(iCNT_CLR), .oDATA(oDATA), .oDATA_V(oDATA_V),
    .oINTV_TS(oINTV_TS), .oINTV_V(oINTV_V), .oBLK_DONE(oBLK_DONE),
    .oERR_SHORT(oERR_SHORT), .oERR_ORPHAN(oERR_ORPHAN), .oERR_ZFILL(oERR_ZFILL),
    .oDATA_CNT(oDATA_CNT), .oINTV_CNT(oINTV_CNT), .oZERO_CNT(oZERO_CNT));

  always #5 iCLK = ~iCLK;

  int nTests = 0;
  int nFail  = 0;

  // Reference model: position in block, whether fill has started, last outputs.
  bit           mActive, mFill;
  int           mPos;
  logic [255:0] mData;
  logic [55:0]  mTs;
  bit           mDataV, mIntvV, mDone, mShort, mOrphan, mZfill;
  int           mDc, mIc, mZc;

  logic [341:0] obsVec, expVec;
  assign obsVec = {oDATA, oDATA_V, oINTV_TS, oINTV_V, oBLK_DONE, oERR_SHORT,
                   oERR_ORPHAN, oERR_ZFILL, oDATA_CNT, oINTV_CNT, oZERO_CNT};
  always_comb expVec = {mData, mDataV, mTs, mIntvV, mDone, mShort, mOrphan, mZfill,
                        CW'(mDc), CW'(mIc), CW'(mZc)};

  function automatic logic [255:0] swap32(input logic [255:0] x);
    logic [255:0] r;
    for (int k = 0; k < 32; k++) r[8*k +: 8] = x[8*(31-k) +: 8];
    return r;
  endfunction

  // Random data beat; non-zero little-endian byte 0 lands in the top byte, so it
  // is never mistaken for fill or an interval beat.
  function automatic logic [255:0] rndData(input logic [7:0] b0);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    r[7:0] = b0;
    return r;
  endfunction

  function automatic logic [255:0] intvBeat(input logic [55:0] ts);
    logic [255:0] b;
    b = {192'd0, ts, 8'h07};
    return swap32(b);
  endfunction

  function automatic int satAdd(input int c, input int a);
    return (c + a > CMAX) ? CMAX : c + a;
  endfunction

  task automatic modelReset();
    mActive = 0; mFill = 0; mPos = 0; mData = '0; mTs = '0;
    mDataV = 0; mIntvV = 0; mDone = 0; mShort = 0; mOrphan = 0; mZfill = 0;
    mDc = 0; mIc = 0; mZc = 0;
  endtask

  task automatic modelStep(input logic [255:0] d, input bit v, input bit sob, input bit clr);
    logic [255:0] be;
    bit isZ, isI;
    int aD, aI, aZ;
    be  = swap32(d);
    isZ = (be == '0);
    isI = (be[7:0] == 8'h07) && (be[255:64] == '0);
    aD = 0; aI = 0; aZ = 0;
    mDataV = 0; mIntvV = 0; mDone = 0; mShort = 0; mOrphan = 0; mZfill = 0;
    if (v) begin
      if (!mActive && !sob) mOrphan = 1;
      else begin
        if (sob) begin
          if (mActive) mShort = 1;
          mActive = 1; mPos = 0; mFill = 0;
        end
        if (mFill) begin
          if (isZ) aZ = 1; else mZfill = 1;
        end else if (isZ) begin
          aZ = 1; mFill = 1;
        end else if (isI) begin
          aI = 1; mFill = 1; mTs = be[63:8]; mIntvV = 1;
        end else begin
          aD = 1; mData = be; mDataV = 1;
        end
        if (mPos == 127) begin
          mDone = 1; mActive = 0; mPos = 0; mFill = 0;
        end else mPos++;
      end
    end
    if (clr) begin
      mDc = 0; mIc = 0; mZc = 0;
    end else begin
      mDc = satAdd(mDc, aD); mIc = satAdd(mIc, aI); mZc = satAdd(mZc, aZ);
    end
  endtask

  // Drive one cycle, advance the model, sample #1 after the edge.
  task automatic beat(input logic [255:0] d, input bit v, input bit sob, input bit clr);
    iXFR_DATA = d; iXFR_DATA_V = v; iXFR_SOB = sob; iCNT_CLR = clr;
    modelStep(d, v, sob, clr);
    @(posedge iCLK); #1;
    iXFR_DATA_V = 0; iXFR_SOB = 0; iCNT_CLR = 0;
  endtask

  task automatic doReset();
    iRST_N = 0; iXFR_DATA_V = 0; iXFR_SOB = 0; iCNT_CLR = 0;
    modelReset();
    @(posedge iCLK); #1;
    iRST_N = 1;
  endtask

  task automatic test_reset();
    doReset();
    doReset();
    nTests++;
    if (obsVec !== '0) begin
      nFail++; $display("FAIL reset_state got=%h exp=0", obsVec);
    end
  endtask

  task automatic test_full_block();
    int nDone = 0, nV = 0;
    beat('0, 0, 0, 1);
    for (int i = 0; i < 128; i++) begin
      beat(rndData(8'h11), 1, i == 0, 0);
      nDone += oBLK_DONE; nV += oDATA_V;
      nTests++;
      if (obsVec !== expVec || oDATA[255:248] !== 8'h11) begin
        nFail++; $display("FAIL full_block beat%0d got=%h exp=%h", i, obsVec, expVec);
      end
    end
    nTests++;
    if (nV != 128 || nDone != 1 || oBLK_DONE !== 1'b1 || oDATA_CNT !== 8'd128) begin
      nFail++; $display("FAIL full_block_sum got v=%0d done=%0d cnt=%0d exp 128/1/128", nV, nDone, oDATA_CNT);
    end
    // Back in idle: a beat without SOB is an orphan.
    beat(rndData(8'h22), 1, 0, 0);
    nTests++;
    if (oERR_ORPHAN !== 1'b1 || oDATA_V !== 1'b0) begin
      nFail++; $display("FAIL full_block_idle got orphan=%b v=%b exp 1/0", oERR_ORPHAN, oDATA_V);
    end
  endtask

  task automatic test_intv();
    int nIntv = 0;
    beat('0, 0, 0, 1);
    for (int i = 0; i < 128; i++) begin
      if (i < 111)       beat(rndData(8'h5A), 1, i == 0, 0);
      else if (i == 111) beat(intvBeat(56'h0123456789ABCD), 1, 0, 0);
      else               beat('0, 1, 0, 0);
      nIntv += oINTV_V;
      nTests++;
      if (obsVec !== expVec) begin
        nFail++; $display("FAIL intv beat%0d got=%h exp=%h", i, obsVec, expVec);
      end
    end
    nTests++;
    if (nIntv != 1 || oINTV_TS !== 56'h0123456789ABCD || oDATA_CNT !== 8'd111 ||
        oINTV_CNT !== 8'd1 || oZERO_CNT !== 8'd16 || oBLK_DONE !== 1'b1) begin
      nFail++; $display("FAIL intv_sum got n=%0d ts=%h d=%0d i=%0d z=%0d done=%b", nIntv, oINTV_TS,
                        oDATA_CNT, oINTV_CNT, oZERO_CNT, oBLK_DONE);
    end
  endtask

  task automatic test_zfill_err();
    int nErr = 0, nV = 0;
    for (int i = 0; i < 128; i++) begin
      if (i < 5)        beat(rndData(8'h33), 1, i == 0, 0);
      else if (i == 10) beat(rndData(8'h44), 1, 0, 0);
      else              beat('0, 1, 0, 0);
      nErr += oERR_ZFILL; nV += oDATA_V;
      nTests++;
      if (obsVec !== expVec) begin
        nFail++; $display("FAIL zfill beat%0d got=%h exp=%h", i, obsVec, expVec);
      end
      if (i == 10) begin
        nTests++;
        if (oERR_ZFILL !== 1'b1 || oDATA_V !== 1'b0) begin
          nFail++; $display("FAIL zfill_err got err=%b v=%b exp 1/0", oERR_ZFILL, oDATA_V);
        end
      end
    end
    nTests++;
    if (nErr != 1 || nV != 5 || oBLK_DONE !== 1'b1) begin
      nFail++; $display("FAIL zfill_sum got err=%0d v=%0d done=%b exp 1/5/1", nErr, nV, oBLK_DONE);
    end
  endtask

  task automatic test_short();
    int nDone = 0;
    for (int i = 0; i < 40; i++) beat(rndData(8'h55), 1, i == 0, 0);
    for (int i = 0; i < 128; i++) begin
      beat(rndData(8'h66), 1, i == 0, 0);
      nDone += oBLK_DONE;
      nTests++;
      if (obsVec !== expVec) begin
        nFail++; $display("FAIL short beat%0d got=%h exp=%h", i, obsVec, expVec);
      end
      if (i == 0) begin
        nTests++;
        if (oERR_SHORT !== 1'b1) begin
          nFail++; $display("FAIL short_err got=%b exp=1", oERR_SHORT);
        end
      end
    end
    nTests++;
    if (nDone != 1 || oBLK_DONE !== 1'b1) begin
      nFail++; $display("FAIL short_done got n=%0d last=%b exp 1/1", nDone, oBLK_DONE);
    end
  endtask

  task automatic test_orphan_reset();
    int nErr = 0;
    beat(rndData(8'h77), 1, 0, 0);
    nTests++;
    if (oERR_ORPHAN !== 1'b1 || oDATA_V !== 1'b0 || obsVec !== expVec) begin
      nFail++; $display("FAIL orphan got orphan=%b v=%b exp 1/0", oERR_ORPHAN, oDATA_V);
    end
    for (int i = 0; i < 60; i++) beat(rndData(8'h88), 1, i == 0, 0);
    doReset();
    nTests++;
    if (obsVec !== '0) begin
      nFail++; $display("FAIL reset_mid got=%h exp=0", obsVec);
    end
    for (int i = 0; i < 128; i++) begin
      beat(rndData(8'h99), 1, i == 0, 0);
      nErr += oERR_SHORT + oERR_ORPHAN + oERR_ZFILL;
      nTests++;
      if (obsVec !== expVec) begin
        nFail++; $display("FAIL post_reset beat%0d got=%h exp=%h", i, obsVec, expVec);
      end
    end
    nTests++;
    if (nErr != 0 || oDATA_CNT !== 8'd128 || oBLK_DONE !== 1'b1) begin
      nFail++; $display("FAIL post_reset_sum got err=%0d cnt=%0d done=%b exp 0/128/1", nErr, oDATA_CNT, oBLK_DONE);
    end
  endtask

  task automatic test_saturate();
    beat('0, 0, 0, 1);
    for (int i = 0; i < 128; i++) beat(rndData(8'hA1), 1, i == 0, 0);
    for (int i = 0; i < 126; i++) beat(rndData(8'hA2), 1, i == 0, 0);
    nTests++;
    if (oDATA_CNT !== 8'(CMAX - 1)) begin
      nFail++; $display("FAIL sat_pre got=%0d exp=%0d", oDATA_CNT, CMAX - 1);
    end
    beat(rndData(8'hA3), 1, 0, 0);
    beat(rndData(8'hA4), 1, 0, 0);
    nTests++;
    if (oDATA_CNT !== 8'(CMAX) || obsVec !== expVec) begin
      nFail++; $display("FAIL sat_hold got=%0d exp=%0d", oDATA_CNT, CMAX);
    end
    beat(rndData(8'hA5), 1, 1, 1);
    nTests++;
    if (oDATA_CNT !== 8'd0 || oDATA_V !== 1'b1 || obsVec !== expVec) begin
      nFail++; $display("FAIL clr_prio got cnt=%0d v=%b exp 0/1", oDATA_CNT, oDATA_V);
    end
  endtask

  task automatic test_random();
    logic [255:0] d;
    int kind;
    bit v, sob;
    for (int i = 0; i < 1500; i++) begin
      v    = ($urandom_range(0, 9) < 8);
      sob  = mActive ? ($urandom_range(0, 99) < 2) : ($urandom_range(0, 9) < 9);
      kind = $urandom_range(0, 9);
      if (kind < 7)      d = rndData(8'(($urandom & 8'hFE) | 8'h01));
      else if (kind < 9) d = '0;
      else               d = intvBeat(56'({$urandom, $urandom}));
      beat(d, v, sob, $urandom_range(0, 99) == 0);
      nTests++;
      if (obsVec !== expVec) begin
        nFail++; $display("FAIL random cyc%0d got=%h exp=%h", i, obsVec, expVec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_intv();
    test_zfill_err();
    test_short();
    test_orphan_reset();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
